// File: rtl/ym3438_clkgen.sv
// Chip-clock generator: divides MCLK into c1/c2 phase strobes and keeps
// the slot counter that sequences the shift-register and latch primitives.
module ym3438_clkgen #(
   parameter int DIV   = 6,
   parameter int SLOTS = 24
) (
   input  logic       MCLK,
   input  logic       rst,
   input  logic       en,
   input  logic       resync,
   output logic       c1,
   output logic       c2,
   output logic [4:0] cycle,
   output logic       cycle_last,
   output logic       sync
);

   localparam int            PW       = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
   localparam logic [PW-1:0] PH_C2    = PW'(DIV / 2);
   localparam logic [4:0]    CYC_LAST = 5'(SLOTS - 1);

   // Power-up values equal the reset values.
   logic [PW-1:0] phase_q = '0;
   logic [PW-1:0] phase_d;
   logic [4:0]    cycle_q = 5'd0;
   logic [4:0]    cycle_d;
   logic          run_s;

   // Strobes are decoded from the held phase and suppressed by rst/resync.
   always_comb begin
      run_s      = en & ~rst & ~resync;
      c1         = run_s & (phase_q == '0);
      c2         = run_s & (phase_q == PH_C2);
      sync       = c1 & (cycle_q == 5'd0);
      cycle      = cycle_q;
      cycle_last = (cycle_q == CYC_LAST);
   end

   // Next-state: rst > resync > en; the slot index only moves on a c2 edge.
   always_comb begin
      phase_d = phase_q;
      cycle_d = cycle_q;
      if (rst || resync) begin
         phase_d = '0;
         cycle_d = 5'd0;
      end else if (en) begin
         phase_d = (phase_q >= PH_LAST) ? '0 : phase_q + PW'(1);
         if (c2) begin
            cycle_d = (cycle_q >= CYC_LAST) ? 5'd0 : cycle_q + 5'd1;
         end else begin
            cycle_d = cycle_q;
         end
      end else begin
         phase_d = phase_q;
         cycle_d = cycle_q;
      end
   end

   // State registers.
   always_ff @(posedge MCLK) begin
      phase_q <= phase_d;
      cycle_q <= cycle_d;
   end

endmodule

// File: tb/tb_ym3438_clkgen.sv
// Scoreboard bench for ym3438_clkgen (DIV=6, SLOTS=24): per-cycle expected
// strobes/slot index queued at drive time, compared at the falling edge.
module tb_ym3438_clkgen;

   logic       MCLK = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       resync = 1'b0;
   logic       c1, c2, cycle_last, sync;
   logic [4:0] cycle;

   ym3438_clkgen #(.DIV(6), .SLOTS(24)) dut (
      .MCLK(MCLK), .rst(rst), .en(en), .resync(resync),
      .c1(c1), .c2(c2), .cycle(cycle), .cycle_last(cycle_last), .sync(sync)
   );

   always #5 MCLK = ~MCLK;

   typedef struct packed {
      logic       c1;
      logic       c2;
      logic       sync;
      logic       last;
      logic [4:0] cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Reference state
   int m_ph = 0;
   int m_cyc = 0;
   int t = 0;

   // Sampled outputs
   logic       o_c1, o_c2, o_sync, o_last, o_sr;
   logic [4:0] o_cyc;

   // Steady-state bookkeeping
   bit   steady = 1'b0;
   int   prev_sync = -1;
   int   last_cnt = 0;
   int   prev_cyc = 0;

   // Two-stage c1/c2 shift-register primitive
   logic din = 1'b0;
   logic m0, s0, m1, s1;
   always @(posedge MCLK) begin
      if (rst) begin
         m0 <= 1'b0; s0 <= 1'b0; m1 <= 1'b0; s1 <= 1'b0;
      end else begin
         if (c1) begin
            m0 <= din;
            m1 <= s0;
         end
         if (c2) begin
            s0 <= m0;
            s1 <= m1;
         end
      end
   end

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic rs);
      exp_t x;
      exp_t y;
      rst = r; en = e; resync = rs;
      x.c1   = e && !r && !rs && (m_ph == 0);
      x.c2   = e && !r && !rs && (m_ph == 3);
      x.sync = x.c1 && (m_cyc == 0);
      x.last = (m_cyc == 23);
      x.cyc  = 5'(m_cyc);
      sb.push_back(x);
      @(negedge MCLK);
      o_c1 = c1; o_c2 = c2; o_sync = sync; o_last = cycle_last; o_cyc = cycle; o_sr = s1;
      y = sb.pop_front();
      chk("c1", o_c1, y.c1);
      chk("c2", o_c2, y.c2);
      chk("sync", o_sync, y.sync);
      chk("cycle_last", o_last, y.last);
      chk("cycle", o_cyc, y.cyc);
      chk("c1_c2_exclusive", o_c1 & o_c2, 0);
      if (steady) begin
         if (t == 3) chk("c2_at_3", o_c2, 1);
         if (t == 4) chk("cycle_at_4", o_cyc, 1);
         if (o_sync) begin
            if (prev_sync >= 0) chk("sync_period", t - prev_sync, 144);
            prev_sync = t;
         end
         if (o_cyc == 5'd23) last_cnt++;
         if (prev_cyc == 23 && o_cyc == 5'd0) begin
            chk("last_width", last_cnt, 6);
            last_cnt = 0;
         end
         prev_cyc = o_cyc;
      end
      @(posedge MCLK);
      if (r || rs) begin
         m_ph = 0; m_cyc = 0;
      end else if (e) begin
         if (m_ph == 3) m_cyc = (m_cyc + 1) % 24;
         m_ph = (m_ph + 1) % 6;
      end
      t++;
      #1;
   endtask

   task automatic align(input int ph, input int cyc);
      bit found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (m_ph == ph && (cyc < 0 || m_cyc == cyc)) begin
            found = 1'b1;
            break;
         end
         step(1'b0, 1'b1, 1'b0);
      end
      chk("align_reached", found, 1);
   endtask

   initial begin
      int held_cyc;
      @(posedge MCLK);
      #1;
      // Power-up state behaves like reset
      step(1'b0, 1'b1, 1'b0);
      chk("powerup_sync", o_sync, 1);

      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
      chk("reset_cycle", o_cyc, 0);

      // Steady state from release
      t = 0;
      steady = 1'b1;
      for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);
      steady = 1'b0;
      chk("sync_seen", (prev_sync == 288) ? 1 : 0, 1);

      // Pause at phase 2
      align(2, -1);
      held_cyc = m_cyc;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
      chk("pause_cycle_held", o_cyc, held_cyc);
      step(1'b0, 1'b1, 1'b0);
      chk("pause_no_early_c2", o_c2, 0);
      step(1'b0, 1'b1, 1'b0);
      chk("pause_c2_resume", o_c2, 1);
      chk("pause_cycle_after", o_cyc, held_cyc);

      // Resync at cycle 17, phase 3
      align(3, 17);
      step(1'b0, 1'b1, 1'b1);
      chk("resync_no_c2", o_c2, 0);
      step(1'b0, 1'b1, 1'b0);
      chk("resync_c1", o_c1, 1);
      chk("resync_sync", o_sync, 1);
      chk("resync_cycle", o_cyc, 0);

      // Resync with en low still realigns
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      chk("resync_en0_sync", o_sync, 1);

      // Mid-operation reset at cycle 9
      align(1, 9);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
      chk("midrst_cycle", o_cyc, 0);
      step(1'b0, 1'b1, 1'b0);
      chk("midrst_c1", o_c1, 1);
      chk("midrst_sync", o_sync, 1);

      // Shift-register integration: bit presented at a c1 cycle
      align(0, -1);
      din = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      din = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         step(1'b0, 1'b1, 1'b0);
         if (k == 6)  chk("sr_one_clk", o_sr, 0);
         if (k == 12) chk("sr_two_clk", o_sr, 1);
         if (k == 18) chk("sr_three_clk", o_sr, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
